multi_port_register_file: RTL and testbench
===========================================

// Module: multi_port_register_file
// PURPOSE
//  Generalised per-thread register file: CHANNELS vector lanes, READ_PORTS read ports, one write port.
//  - Registered reads, 1-cycle latency.
//  - Optional frame-relative addressing on each read port.
//  - Special-purpose registers: frame offset, index, thread control.
//  - Post-reset / on-demand clear sequencer that zeroes the whole array.
//  Sits between the instruction decoder (reads) and the execution writeback (writes).
// PARAMETERS
//  CHANNELS       3     vector lanes; lane CHANNELS-1 = X (MSB slice), lane 0 = Z (LSB slice)
//  CHANNEL_WIDTH  32    bits per lane
//  ADDR_WIDTH     7     address bits; DEPTH = 2**ADDR_WIDTH entries
//  READ_PORTS     2     number of read ports, 1..4
//  SPR_CTRL0      7'h02 address of thread-control SPR
//  SPR_CTRL1      7'h03 address of frame-offset/index SPR
// PORTS
//  Clock             in   1                       clock
//  Reset             in   1                       synchronous, active-high reset
//  iClearRequest     in   1                       start array clear (sampled only in READY)
//  iReadAddress      in   READ_PORTS*ADDR_WIDTH   port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//  iReadRelative     in   READ_PORTS              1 = address is relative to frame offset
//  iWriteEnable      in   CHANNELS                bit c writes lane c
//  iWriteAddress     in   ADDR_WIDTH              absolute write address
//  iData             in   CHANNELS*CHANNEL_WIDTH  write data
//  oData             out  READ_PORTS*CHANNELS*CHANNEL_WIDTH  read data, port p at [p*CHANNELS*CHANNEL_WIDTH +: ...]
//  oReadValid        out  1                       oData holds reads issued on the previous cycle
//  oBusy             out  1                       clear in progress; reads and writes are ignored
//  oFrameOffset      out  ADDR_WIDTH              frame offset SPR
//  oIndexRegister    out  ADDR_WIDTH              index SPR, forwarded same cycle
//  oThreadControl    out  CHANNEL_WIDTH           thread-control SPR
// BEHAVIOUR
//  Reset values
//  - oData, oFrameOffset, oIndexRegister, oThreadControl = 0; oReadValid = 0; oBusy = 1.
//  - The FSM enters CLEAR with the clear pointer at 0.
//  FSM (CLEAR, READY)
//  - CLEAR: each cycle writes 0 to all lanes at ptr, then ptr++.
//  - At ptr == DEPTH-1 the FSM goes to READY on the next edge. A clear takes exactly DEPTH cycles.
//  - READY with iClearRequest = 1: go to CLEAR, ptr = 0. The write on that same cycle is dropped.
//  - Reset mid-clear restarts the clear from ptr 0.
//  - oBusy = (state == CLEAR).
//  - A clear does not alter the SPRs; only Reset clears them.
//  Reads (READY only)
//  - Effective address ea = iReadRelative[p] ? (addr + oFrameOffset) mod DEPTH : addr. Wraps silently.
//  - oData is registered: lane data at ea appears the next cycle.
//  - oReadValid is a registered copy of (state == READY). It is 0 on the first cycle after entering READY. While busy, oData holds its last value.
//  Writes (READY only)
//  - Lane c is written at iWriteAddress when iWriteEnable[c] = 1. Lanes with enable 0 are untouched.
//  - Same-cycle read and write to the same address: see CONFIGURATION.
//  SPRs (updated on writes in READY, independent of the array write)
//  - Write to SPR_CTRL1 with iWriteEnable[CHANNELS-1]: oFrameOffset <= X lane[ADDR_WIDTH-1:0].
//  - Write to SPR_CTRL1 with iWriteEnable[0]: index <= Z lane[ADDR_WIDTH-1:0].
//  - oIndexRegister is combinational forwarding: shows the Z-lane value on the write cycle, else the stored index.
//  - Write to SPR_CTRL0 with iWriteEnable[0]: oThreadControl <= Z lane.
//  - Relative reads in the cycle that writes the frame offset use the OLD offset.
// CONFIGURATION
//  RF_WRITE_BYPASS_EN
//  - Defined: a read whose ea equals iWriteAddress in the same cycle returns iData for enabled lanes, and the array value for disabled lanes.
//  - Undefined: such a read returns the pre-write array value (read-before-write).
// STRUCTURE
//  - Package rf_pkg: state enum {RF_CLEAR, RF_READY}; default SPR_CTRL0/SPR_CTRL1 constants; lane-slice helper function lane(c).
//  - Sub-module rf_lane_bank: one lane, 1 write port / READ_PORTS registered read ports.
//    - Instantiated CHANNELS times via generate.
//    - Write port muxed between the clear sequencer and the writeback port.
// TESTING
//  1 Reset 1 cycle, then release -> oBusy=1 for exactly 128 cycles; then oBusy=0, and all 128 addresses read 0.
//  2 READY: write addr 5, WE=3'b111, data {32'hA,32'hB,32'hC}; read port0 addr 5 next cycle -> oData port0 = {A,B,C} one cycle later, oReadValid=1.
//  3 Write SPR_CTRL1, X=7'h7E, WE=3'b100; then relative read addr 3 on port1 -> ea = 7'h01, returns entry 1.
//  4 Write SPR_CTRL1, Z=7'h11, WE=3'b001 -> oIndexRegister=7'h11 in the same cycle; it holds after.
//  5 Same-cycle write addr 9 (WE=3'b010, Y=32'hDEAD) + read addr 9 -> Y=DEAD with RF_WRITE_BYPASS_EN, old Y without it; X and Z old in both builds.
//  6 Assert Reset at clear ptr 60 -> clear restarts; oBusy stays 1 for 128 cycles after release. iClearRequest in READY -> another 128-cycle clear, SPRs unchanged.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
// Macro RF_WRITE_BYPASS_EN selects same-cycle write-to-read forwarding in the lane banks.
package rf_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  localparam int unsigned RF_SPR_CTRL0 = 32'h02;
  localparam int unsigned RF_SPR_CTRL1 = 32'h03;

  // Bit offset of slice c in a bus of width-wide slices.
  function automatic int lane(input int c, input int width);
    return c * width;
  endfunction

endpackage

// File: rtl/multi_port_register_file_if.sv
// Decoder/writeback-facing bus of the register file; master drives reads/writes, slave is the RF.
// No backpressure: writes are dropped and read data is stale while busy is high.
interface multi_port_register_file_if #(
  parameter int CHANNELS      = 3,
  parameter int CHANNEL_WIDTH = 32,
  parameter int ADDR_WIDTH    = 7,
  parameter int READ_PORTS    = 2
);
  logic                                       clear_req;
  logic [READ_PORTS*ADDR_WIDTH-1:0]           rd_addr;
  logic [READ_PORTS-1:0]                      rd_rel;
  logic [CHANNELS-1:0]                        wr_en;
  logic [ADDR_WIDTH-1:0]                      wr_addr;
  logic [CHANNELS*CHANNEL_WIDTH-1:0]          wr_dat;
  logic [READ_PORTS*CHANNELS*CHANNEL_WIDTH-1:0] rd_dat;
  logic                                       rd_vld;
  logic                                       busy;
  logic [ADDR_WIDTH-1:0]                      frame_offset;
  logic [ADDR_WIDTH-1:0]                      index_reg;
  logic [CHANNEL_WIDTH-1:0]                   thread_ctrl;

  modport master (
    output clear_req, rd_addr, rd_rel, wr_en, wr_addr, wr_dat,
    input  rd_dat, rd_vld, busy, frame_offset, index_reg, thread_ctrl
  );

  modport slave (
    input  clear_req, rd_addr, rd_rel, wr_en, wr_addr, wr_dat,
    output rd_dat, rd_vld, busy, frame_offset, index_reg, thread_ctrl
  );
endinterface

// File: rtl/rf_lane_bank.sv
// One vector lane: 1 write port, READ_PORTS registered read ports (1-cycle latency, no backpressure).
// RF_WRITE_BYPASS_EN: a read hitting the same-cycle write address returns the write data.
module rf_lane_bank #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int READ_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [WIDTH-1:0]                 wdat,
  input  logic                             rd_en,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [READ_PORTS*WIDTH-1:0]      rdat
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents are zeroed by the clear sequencer, not by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdat <= '0;
    end else if (rd_en) begin
      for (int p = 0; p < READ_PORTS; p++) begin
`ifdef RF_WRITE_BYPASS_EN
        if (we && (raddr[p*ADDR_WIDTH +: ADDR_WIDTH] == waddr))
          rdat[p*WIDTH +: WIDTH] <= wdat;
        else
          rdat[p*WIDTH +: WIDTH] <= mem[raddr[p*ADDR_WIDTH +: ADDR_WIDTH]];
`else
        rdat[p*WIDTH +: WIDTH] <= mem[raddr[p*ADDR_WIDTH +: ADDR_WIDTH]];
`endif
      end
    end
  end

endmodule

// File: rtl/multi_port_register_file.sv
// Per-thread vector register file with SPRs and a DEPTH-cycle clear sequencer; reads 1-cycle latency.
// busy high during clear (reads/writes ignored); RF_WRITE_BYPASS_EN enables write-to-read forwarding.
module multi_port_register_file
  import rf_pkg::*;
#(
  parameter int CHANNELS      = 3,
  parameter int CHANNEL_WIDTH = 32,
  parameter int ADDR_WIDTH    = 7,
  parameter int READ_PORTS    = 2,
  parameter logic [ADDR_WIDTH-1:0] SPR_CTRL0 = ADDR_WIDTH'(RF_SPR_CTRL0),
  parameter logic [ADDR_WIDTH-1:0] SPR_CTRL1 = ADDR_WIDTH'(RF_SPR_CTRL1)
) (
  input logic                        clk,
  input logic                        rst,
  multi_port_register_file_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  rf_state_t                 state;
  logic [ADDR_WIDTH-1:0]     ptr;
  logic [ADDR_WIDTH-1:0]     frame_q;
  logic [ADDR_WIDTH-1:0]     index_q;
  logic [CHANNEL_WIDTH-1:0]  tc_q;
  logic                      vld_q;

  logic clearing, ready, wb_ok;
  logic fo_wr, idx_wr, tc_wr;
  logic [CHANNEL_WIDTH-1:0] z_dat;

  assign clearing = (state == RF_CLEAR);
  assign ready    = (state == RF_READY);
  // A clear request wins over a same-cycle write, including SPR writes.
  assign wb_ok    = ready && !bus.clear_req && !rst;
  assign z_dat    = bus.wr_dat[lane(0, CHANNEL_WIDTH) +: CHANNEL_WIDTH];
  assign fo_wr    = wb_ok && (bus.wr_addr == SPR_CTRL1) && bus.wr_en[CHANNELS-1];
  assign idx_wr   = wb_ok && (bus.wr_addr == SPR_CTRL1) && bus.wr_en[0];
  assign tc_wr    = wb_ok && (bus.wr_addr == SPR_CTRL0) && bus.wr_en[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      ptr     <= '0;
      frame_q <= '0;
      index_q <= '0;
      tc_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= ready;
      case (state)
        RF_CLEAR: begin
          ptr <= ptr + ADDR_WIDTH'(1);
          if (ptr == ADDR_WIDTH'(DEPTH - 1)) state <= RF_READY;
        end
        RF_READY: begin
          if (bus.clear_req) begin
            state <= RF_CLEAR;
            ptr   <= '0;
          end
        end
        default: state <= RF_CLEAR;
      endcase
      if (fo_wr)  frame_q <= bus.wr_dat[lane(CHANNELS-1, CHANNEL_WIDTH) +: ADDR_WIDTH];
      if (idx_wr) index_q <= z_dat[ADDR_WIDTH-1:0];
      if (tc_wr)  tc_q    <= z_dat;
    end
  end

  // Relative reads use the registered offset, so a same-cycle offset write is not seen yet.
  logic [READ_PORTS*ADDR_WIDTH-1:0] ea;
  always_comb begin
    ea = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      ea[p*ADDR_WIDTH +: ADDR_WIDTH] = bus.rd_rel[p]
        ? bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] + frame_q
        : bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  logic [ADDR_WIDTH-1:0]              bank_waddr;
  logic [READ_PORTS*CHANNEL_WIDTH-1:0] lane_rdat [CHANNELS];

  assign bank_waddr = clearing ? ptr : bus.wr_addr;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic                     we_c;
    logic [CHANNEL_WIDTH-1:0] wdat_c;

    assign we_c   = clearing | (wb_ok & bus.wr_en[c]);
    assign wdat_c = clearing ? '0 : bus.wr_dat[lane(c, CHANNEL_WIDTH) +: CHANNEL_WIDTH];

    rf_lane_bank #(
      .WIDTH      (CHANNEL_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .READ_PORTS (READ_PORTS)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (we_c),
      .waddr (bank_waddr),
      .wdat  (wdat_c),
      .rd_en (ready),
      .raddr (ea),
      .rdat  (lane_rdat[c])
    );

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      assign bus.rd_dat[lane(p*CHANNELS + c, CHANNEL_WIDTH) +: CHANNEL_WIDTH] =
        lane_rdat[c][lane(p, CHANNEL_WIDTH) +: CHANNEL_WIDTH];
    end
  end

  assign bus.busy         = clearing;
  assign bus.rd_vld       = vld_q;
  assign bus.frame_offset = frame_q;
  assign bus.index_reg    = idx_wr ? z_dat[ADDR_WIDTH-1:0] : index_q;
  assign bus.thread_ctrl  = tc_q;

endmodule

// File: tb/tb_multi_port_register_file.sv
// Scoreboard bench for multi_port_register_file: stimulus queues expected outputs by cycle, a monitor checks them.
module tb_multi_port_register_file;
  localparam int C = 3, W = 32, AW = 7, RP = 2, LW = C * W;
  localparam int K_RD = 0, K_VLD = 1, K_BUSY = 2, K_IDX = 3, K_FO = 4, K_TC = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_port_register_file_if #(.CHANNELS(C), .CHANNEL_WIDTH(W), .ADDR_WIDTH(AW), .READ_PORTS(RP)) bus ();

  multi_port_register_file #(.CHANNELS(C), .CHANNEL_WIDTH(W), .ADDR_WIDTH(AW), .READ_PORTS(RP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int             kind;
    int             port;
    int             at;
    logic [LW-1:0]  val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic expect_at(input int kind, input int port, input int at, input logic [LW-1:0] val);
    exp_t e;
    e.kind = kind; e.port = port; e.at = at; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clear_req = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_rel    = '0;
    bus.wr_en     = '0;
    bus.wr_addr   = '0;
    bus.wr_dat    = '0;
  endtask

  task automatic set_read(input int p, input logic [AW-1:0] a, input logic rel);
    bus.rd_addr[p*AW +: AW] = a;
    bus.rd_rel[p]           = rel;
  endtask

  task automatic set_write(input logic [AW-1:0] a, input logic [C-1:0] we, input logic [LW-1:0] d);
    bus.wr_addr = a;
    bus.wr_en   = we;
    bus.wr_dat  = d;
  endtask

  task automatic exp_read(input int p, input logic [LW-1:0] v);
    expect_at(K_RD, p, cyc + 1, v);
    expect_at(K_VLD, 0, cyc + 1, LW'(1));
  endtask

  task automatic exp_busy(input int start, input int ones, input bit zero_after);
    for (int i = 0; i < ones; i++) expect_at(K_BUSY, 0, start + i, LW'(1));
    if (zero_after) expect_at(K_BUSY, 0, start + ones, LW'(0));
  endtask

  function automatic string kname(input int kind);
    case (kind)
      K_RD:    return "rd_dat";
      K_VLD:   return "rd_vld";
      K_BUSY:  return "busy";
      K_IDX:   return "index_reg";
      K_FO:    return "frame_offset";
      default: return "thread_ctrl";
    endcase
  endfunction

  function automatic logic [LW-1:0] actual(input int kind, input int port);
    logic [LW-1:0] a;
    a = '0;
    case (kind)
      K_RD:    a = bus.rd_dat[port*LW +: LW];
      K_VLD:   a[0] = bus.rd_vld;
      K_BUSY:  a[0] = bus.busy;
      K_IDX:   a[AW-1:0] = bus.index_reg;
      K_FO:    a[AW-1:0] = bus.frame_offset;
      default: a[W-1:0] = bus.thread_ctrl;
    endcase
    return a;
  endfunction

  // Monitor: compare every expectation due this cycle; anything overdue is a miss.
  always @(negedge clk) begin : mon
    int            i;
    logic [LW-1:0] a;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].at == cyc) begin
        a = actual(exp_q[i].kind, exp_q[i].port);
        n_checks++;
        if (a === exp_q[i].val) n_pass++;
        else $display("FAIL %s port%0d cyc%0d: got %h expected %h",
                      kname(exp_q[i].kind), exp_q[i].port, cyc, a, exp_q[i].val);
        exp_q.delete(i);
      end else if (exp_q[i].at < cyc) begin
        n_checks++;
        $display("FAIL %s port%0d overdue at cyc%0d: got none expected %h",
                 kname(exp_q[i].kind), exp_q[i].port, exp_q[i].at, exp_q[i].val);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin : stim
    int c;
    int r;
    logic [LW-1:0] byp_exp;
    idle();
    rst = 1'b1;
    tick();
    // Reset state
    expect_at(K_VLD,  0, cyc, LW'(0));
    expect_at(K_RD,   0, cyc, LW'(0));
    expect_at(K_RD,   1, cyc, LW'(0));
    expect_at(K_FO,   0, cyc, LW'(0));
    expect_at(K_IDX,  0, cyc, LW'(0));
    expect_at(K_TC,   0, cyc, LW'(0));
    rst = 1'b0;
    exp_busy(cyc, 128, 1'b1);
    repeat (128) tick();
    expect_at(K_VLD, 0, cyc, LW'(0));

    // Whole array reads zero after the post-reset clear
    for (int i = 0; i < 64; i++) begin
      set_read(0, AW'(i), 1'b0);
      set_read(1, AW'(i + 64), 1'b0);
      exp_read(0, LW'(0));
      exp_read(1, LW'(0));
      tick();
    end
    idle();

    // Full-lane write then read back
    set_write(7'd5, 3'b111, {32'hA, 32'hB, 32'hC});
    tick();
    set_write(7'd1, 3'b111, {32'h1, 32'h2, 32'h3});
    set_read(0, 7'd5, 1'b0);
    exp_read(0, {32'hA, 32'hB, 32'hC});
    tick();
    idle();

    // Frame offset write; same-cycle relative read still uses offset 0
    set_write(7'h03, 3'b100, {32'h7E, 32'h0, 32'h0});
    set_read(1, 7'd5, 1'b1);
    exp_read(1, {32'hA, 32'hB, 32'hC});
    expect_at(K_FO,  0, cyc,     LW'(0));
    expect_at(K_FO,  0, cyc + 1, LW'(7'h7E));
    expect_at(K_IDX, 0, cyc,     LW'(0));
    tick();
    idle();
    set_read(1, 7'd3, 1'b1);
    exp_read(1, {32'h1, 32'h2, 32'h3});
    set_read(0, 7'd3, 1'b0);
    exp_read(0, {32'h7E, 32'h0, 32'h0});
    tick();
    idle();

    // Index SPR forwarded on the write cycle, then held; X disabled leaves offset alone
    set_write(7'h03, 3'b001, {32'hFFFF_FFFF, 32'h5555_5555, 32'h1234_5611});
    expect_at(K_IDX, 0, cyc,     LW'(7'h11));
    expect_at(K_IDX, 0, cyc + 1, LW'(7'h11));
    expect_at(K_IDX, 0, cyc + 2, LW'(7'h11));
    expect_at(K_FO,  0, cyc + 1, LW'(7'h7E));
    tick();
    idle();
    set_read(0, 7'h03, 1'b0);
    exp_read(0, {32'h7E, 32'h0, 32'h1234_5611});
    tick();
    idle();

    // Thread control: Z-lane write updates it, X-only write does not
    set_write(7'h02, 3'b001, {32'h0, 32'h0, 32'hCAFE_F00D});
    expect_at(K_TC, 0, cyc,     LW'(0));
    expect_at(K_TC, 0, cyc + 1, LW'(32'hCAFE_F00D));
    tick();
    set_write(7'h02, 3'b100, {32'h1, 32'h0, 32'h0BAD});
    expect_at(K_TC, 0, cyc + 1, LW'(32'hCAFE_F00D));
    tick();
    idle();

    // Same-cycle write/read collision on a single lane
    set_write(7'd9, 3'b111, {32'h11, 32'h22, 32'h33});
    tick();
    set_write(7'd9, 3'b010, {32'hFFFF, 32'hDEAD, 32'hEEEE});
    set_read(0, 7'd9, 1'b0);
`ifdef RF_WRITE_BYPASS_EN
    byp_exp = {32'h11, 32'hDEAD, 32'h33};
`else
    byp_exp = {32'h11, 32'h22, 32'h33};
`endif
    exp_read(0, byp_exp);
    tick();
    idle();
    set_read(0, 7'd9, 1'b0);
    exp_read(0, {32'h11, 32'hDEAD, 32'h33});
    tick();
    idle();

    // On-demand clear: same-cycle SPR write dropped, SPRs survive, array zeroed
    c = cyc;
    bus.clear_req = 1'b1;
    set_write(7'h02, 3'b001, {32'h0, 32'h0, 32'h0BAD_0BAD});
    expect_at(K_VLD, 0, c + 1, LW'(1));
    expect_at(K_VLD, 0, c + 2, LW'(0));
    exp_busy(c + 1, 128, 1'b1);
    tick();
    idle();
    repeat (128) tick();
    expect_at(K_VLD, 0, cyc, LW'(0));
    expect_at(K_TC,  0, cyc, LW'(32'hCAFE_F00D));
    expect_at(K_FO,  0, cyc, LW'(7'h7E));
    expect_at(K_IDX, 0, cyc, LW'(7'h11));
    set_read(0, 7'd5, 1'b0);
    set_read(1, 7'd9, 1'b0);
    exp_read(0, LW'(0));
    exp_read(1, LW'(0));
    tick();
    idle();

    // Reset at clear pointer 60 restarts the full clear and zeroes the SPRs
    c = cyc;
    bus.clear_req = 1'b1;
    exp_busy(c + 1, 61, 1'b0);
    tick();
    idle();
    repeat (60) tick();
    rst = 1'b1;
    r = cyc;
    tick();
    rst = 1'b0;
    expect_at(K_FO,  0, r + 1, LW'(0));
    expect_at(K_IDX, 0, r + 1, LW'(0));
    expect_at(K_TC,  0, r + 1, LW'(0));
    expect_at(K_VLD, 0, r + 1, LW'(0));
    exp_busy(cyc, 128, 1'b1);
    repeat (128) tick();
    set_read(0, 7'h03, 1'b0);
    set_read(1, 7'h01, 1'b1);
    exp_read(0, LW'(0));
    exp_read(1, LW'(0));
    tick();
    idle();
    repeat (3) tick();

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d unchecked expectations required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
